// File: rtl/out_mem_streamer_if.sv
// ============================================================================
// Module   : out_mem_streamer_if
// Brief    : Output-memory read port and pixel stream bundle for the streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface out_mem_streamer_if #(
    parameter int DATA_W = 8
);
    logic              mem_en;
    logic              mem_read;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_sof;
    logic              px_eol;
    logic              px_eof;

    modport master (
        output mem_en, mem_read, mem_addr,
        input  mem_rdata,
        output px_data, px_valid, px_sof, px_eol, px_eof,
        input  px_ready
    );

    modport slave (
        input  mem_en, mem_read, mem_addr,
        output mem_rdata,
        input  px_data, px_valid, px_sof, px_eol, px_eof,
        output px_ready
    );
endinterface

`default_nettype wire

// File: rtl/out_mem_streamer.sv
// ============================================================================
// Module   : out_mem_streamer
// Brief    : Reads the output memory 0..SIZE-1 and streams pixels with tags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_mem_streamer #(
    parameter int WIDTH  = 1024,
    parameter int HEIGHT = 768,
    parameter int DATA_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    output logic                busy,
    output logic                frame_done,
    out_mem_streamer_if.master  bus
);

    localparam logic [31:0] c_SIZE  = 32'(WIDTH * HEIGHT);
    localparam int          c_COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int          c_ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } entry_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_issue_cnt;
    logic                 r_inflight;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [1:0]           r_buf_cnt;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    entry_t               r_buf [2];

    logic                 w_pop;
    logic                 w_issue;
    logic [2:0]           w_credit;
    entry_t               w_head;
    entry_t               w_new;
    logic                 w_valid;

    // Credit counts buffered + in-flight words, minus a beat leaving this cycle,
    // so a read can be issued in the same cycle that px_ready frees a slot.
    always_comb begin
        w_valid  = (r_buf_cnt != 2'd0);
        w_pop    = w_valid && bus.px_ready;
        w_credit = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue  = (r_state == S_RUN) && (r_issue_cnt < c_SIZE) && (w_credit <= 3'd1);
        w_head   = r_buf[r_rd_ptr];
        w_new.data = bus.mem_rdata;
        w_new.sof  = (r_col == '0) && (r_row == '0);
        w_new.eol  = (r_col == c_COL_LAST);
        w_new.eof  = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_pop && w_head.eof) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.mem_en   = w_issue;
    assign bus.mem_read = w_issue;
    assign bus.mem_addr = w_issue ? r_issue_cnt : 32'd0;
    assign bus.px_valid = w_valid;
    assign bus.px_data  = w_valid ? w_head.data : '0;
    assign bus.px_sof   = w_valid && w_head.sof;
    assign bus.px_eol   = w_valid && w_head.eol;
    assign bus.px_eof   = w_valid && w_head.eof;
    assign busy         = (r_state == S_RUN) || (r_state == S_DONE);
    assign frame_done   = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= 32'd0;
            r_inflight  <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_buf_cnt   <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_buf_cnt  <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

            if ((r_state == S_IDLE) && start) begin
                r_issue_cnt <= 32'd0;
                r_col       <= '0;
                r_row       <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end

            // Tags follow the returning data, so col/row advance on return.
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= w_new;
                r_wr_ptr        <= ~r_wr_ptr;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst) r_buf_cnt <= 2'd2);

endmodule

`default_nettype wire

// File: tb/tb_out_mem_streamer.sv
// ============================================================================
// Module   : tb_out_mem_streamer
// Brief    : Scoreboard bench for out_mem_streamer on a 4x2 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_out_mem_streamer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    out_mem_streamer_if #(.DATA_W(DW)) bus ();

    out_mem_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // {data, sof, eol, eof} for the 4x2 frame preloaded with 0x10..0x17
    logic [10:0] c_EXP [8] = '{
        {8'h10, 3'b100}, {8'h11, 3'b000}, {8'h12, 3'b000}, {8'h13, 3'b010},
        {8'h14, 3'b000}, {8'h15, 3'b000}, {8'h16, 3'b000}, {8'h17, 3'b011}
    };
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  mem [8];
    logic [10:0] exp_q [$];

    int tests = 0, fails = 0;
    int cyc = 0, t0 = 0;
    int beats, reads, fd_cnt, first_mem, first_valid, fd_cyc, occ;
    logic [31:0] exp_addr;
    bit          hold_v = 1'b0;
    logic [10:0] hold_d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        bus.mem_rdata <= (bus.mem_en && bus.mem_read) ? mem[bus.mem_addr[2:0]] : 8'hEE;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h", name, got, want);
        end
    endfunction

    // Monitor: scoreboard pop, hold stability, read-address order, occupancy
    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        bit          pop;
        cur = {bus.px_data, bus.px_sof, bus.px_eol, bus.px_eof};
        pop = bus.px_valid && bus.px_ready;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("hold_stable", 64'({bus.px_valid, cur}), 64'({1'b1, hold_d}));
            hold_v = bus.px_valid && !bus.px_ready;
            hold_d = cur;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(cur), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                beats++;
            end
            if (bus.mem_en || bus.mem_read) begin
                check("mem_read_eq_en", 64'(bus.mem_read), 64'(bus.mem_en));
                check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                exp_addr = exp_addr + 32'd1;
                reads++;
                if (first_mem < 0) first_mem = cyc - t0;
            end
            occ = occ + (bus.mem_en ? 1 : 0) - (pop ? 1 : 0);
            if (occ > 2) check("occupancy", 64'(occ), 64'd2);
            if (bus.px_valid && first_valid < 0) first_valid = cyc - t0;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc - t0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        beats = 0; reads = 0; fd_cnt = 0; occ = 0;
        first_mem = -1; first_valid = -1; fd_cyc = -1;
        exp_addr = 32'd0;
        t0 = cyc;
    endtask

    task automatic push_frame();
        foreach (c_EXP[i]) exp_q.push_back(c_EXP[i]);
    endtask

    task automatic check_idle_outputs(string name);
        check(name, 64'({bus.mem_en, bus.mem_read, bus.mem_addr, bus.px_valid, bus.px_data,
                         bus.px_sof, bus.px_eol, bus.px_eof, busy, frame_done}), 64'd0);
    endtask

    // mode 0: ready=1; mode 1: ready pattern 1,0,0,1; mode 3: extra starts in RUN/DONE
    task automatic run_frame(input int mode, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            start        = (k == 0) || (mode == 3 && (k == 5 || frame_done));
            bus.px_ready = (mode == 1) ? pat[k % 4] : 1'b1;
            @(negedge clk);
            if (frame_done) seen = 1'b1;
            tick();
        end
        start        = 1'b0;
        bus.px_ready = 1'b1;
        check("frame_done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        bit hit;
        foreach (mem[i]) mem[i] = 8'h10 + 8'(i);
        bus.px_ready = 1'b1;
        clear_stats();
        repeat (3) tick();
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        tick();

        // Free-running frame: timing and ordering
        clear_stats(); push_frame();
        run_frame(0, 40);
        check("t1_first_mem_cycle", 64'(first_mem), 64'd1);
        check("t1_first_valid_cycle", 64'(first_valid), 64'd3);
        check("t1_frame_done_cycle", 64'(fd_cyc), 64'd11);
        check("t1_reads", 64'(reads), 64'd8);
        check("t1_beats", 64'(beats), 64'd8);
        check("t1_idle_busy", 64'(busy), 64'd0);
        tick();

        // Toggling backpressure
        clear_stats(); push_frame();
        run_frame(1, 80);
        check("t2_beats", 64'(beats), 64'd8);
        check("t2_reads", 64'(reads), 64'd8);
        check("t2_fd_cnt", 64'(fd_cnt), 64'd1);
        tick();

        // Full stall from cycle 0
        clear_stats(); push_frame();
        bus.px_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("t3_reads_stalled", 64'(reads), 64'd2);
        check("t3_valid_head", 64'({bus.px_valid, bus.px_data, bus.px_sof}), 64'({1'b1, 8'h10, 1'b1}));
        check("t3_mem_en_low", 64'(bus.mem_en), 64'd0);
        bus.px_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (frame_done) hit = 1'b1;
            tick();
        end
        check("t3_frame_done_seen", 64'(hit), 64'd1);
        check("t3_beats", 64'(beats), 64'd8);
        tick();

        // Reset mid-frame after the 4th beat
        clear_stats(); push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(negedge clk);
            if (beats == 4) hit = 1'b1;
            else tick();
        end
        check("t4_four_beats_seen", 64'(hit), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("t4_reset_outputs");
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("t4_late_rdata_ignored", 64'(bus.px_valid), 64'd0);
        tick();
        clear_stats(); push_frame();
        run_frame(0, 40);
        check("t4_rerun_beats", 64'(beats), 64'd8);
        tick();

        // start during RUN and DONE is ignored
        clear_stats(); push_frame();
        run_frame(3, 40);
        repeat (15) tick();
        check("t5_fd_cnt", 64'(fd_cnt), 64'd1);
        check("t5_beats", 64'(beats), 64'd8);
        check("t5_busy", 64'(busy), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
